// File: rtl/iddmm_pkg.sv
// Shared types and helpers for the IDDMM loop sequencer.
//   iddmm_loop_state_t : sequencer FSM states
//   iddmm_tag_t        : one write tag travelling down the tag pipe
//                        (addr is sized for the largest supported
//                        word count; users take the low ADDR_W+1 bits)
//   drain_cycles()     : drain length D that covers the datapath latency
//   addr_width()       : word address width, never below 1
package iddmm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INNER,
        DRAIN,
        DONE
    } iddmm_loop_state_t;

    localparam int TAG_ADDR_W = 16;

    typedef struct packed {
        logic                  vld;
        logic [TAG_ADDR_W-1:0] addr;
    } iddmm_tag_t;

    localparam int TAG_W = $bits(iddmm_tag_t);

    // Operand read (1) + operand register (1) + datapath (mul_lat)
    // + result register (1).
    function automatic int drain_cycles(input int mul_lat);
        return mul_lat + 3;
    endfunction

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iddmm_tag_pipe.sv
// Fixed-depth shift register of write tags.
//   clk, rst_n : clock, asynchronous active-low reset (clears every stage)
//   tag_i      : tag entering this cycle
//   tag_o      : tag that entered DEPTH cycles ago
module iddmm_tag_pipe
    import iddmm_pkg::*;
#(
    parameter int DEPTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [TAG_W-1:0] tag_i,
    output logic [TAG_W-1:0] tag_o
);

    logic [TAG_W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int s = 1; s < DEPTH; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/iddmm_loop_ctrl.sv
// Loop sequencer for the IDDMM Montgomery core. Walks outer index i over
// 0..N-1 and inner index j over 0..N, fetches x[i] / y[(j+1) mod N] and
// returns datapath results to the accumulator as a write stream.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : one-cycle request, honoured only in IDLE
//   busy, done            : running flag, one-cycle completion pulse
//   x_raddr, y_raddr      : operand RAM read addresses (combinational)
//   x_rdata, y_rdata      : operand RAM data, one cycle after the address
//   i_cnt, j_cnt          : loop indices
//   x, y_adv              : registered operand words
//   acc_in                : datapath result word
//   wr_a_en/addr/data     : accumulator write stream
//   perf_cycles           : busy-cycle counter, present only when
//                           IDDMM_LOOP_CTRL_PERF_EN is defined
// Handshake: start is a level sampled on the rising edge while IDLE; it is
// ignored in every other state. A write is valid exactly in cycles where
// wr_a_en is high; there is no back-pressure.
module iddmm_loop_ctrl
    import iddmm_pkg::*;
#(
    parameter int K       = 128,
    parameter int N       = 32,
    parameter int ADDR_W  = addr_width(N),
    parameter int MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] x_raddr,
    output logic [ADDR_W-1:0] y_raddr,
    input  logic [K-1:0]      x_rdata,
    input  logic [K-1:0]      y_rdata,
    output logic [ADDR_W-1:0] i_cnt,
    output logic [ADDR_W:0]   j_cnt,
    output logic [K-1:0]      x,
    output logic [K-1:0]      y_adv,
    input  logic [K-1:0]      acc_in,
    output logic              wr_a_en,
    output logic [ADDR_W:0]   wr_a_addr,
    output logic [K-1:0]      wr_a_data
`ifdef IDDMM_LOOP_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    localparam int D   = drain_cycles(MUL_LAT);
    localparam int DCW = $clog2(D + 1);

    localparam logic [ADDR_W:0]   J_LAST       = (ADDR_W+1)'(N);
    localparam logic [ADDR_W:0]   J_WRAP       = (ADDR_W+1)'(N - 1);
    localparam logic [ADDR_W-1:0] I_LAST       = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] Y_AFTER_LAST = ADDR_W'((N + 1) % N);
    localparam logic [DCW-1:0]    D_LAST       = DCW'(D - 1);

    iddmm_loop_state_t state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [ADDR_W:0]   j_q, j_d;
    logic [DCW-1:0]    dcnt_q, dcnt_d;
    logic [K-1:0]      x_q, y_q, wdata_q;
    logic              push_vld;
    iddmm_tag_t        tag_in, tag_out;
    logic              tag_addr_unused;

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        dcnt_d   = dcnt_q;
        push_vld = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = INNER;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            INNER: begin
                push_vld = 1'b1;
                if (j_q == J_LAST) begin
                    state_d = DRAIN;
                    dcnt_d  = '0;
                end else begin
                    j_d = j_q + (ADDR_W+1)'(1);
                end
            end
            DRAIN: begin
                // Holds off the next iteration until the last tag of this
                // one has left the pipe, so iterations never interleave.
                if (dcnt_q == D_LAST) begin
                    if (i_q == I_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = INNER;
                        i_d     = i_q + ADDR_W'(1);
                        j_d     = '0;
                    end
                end else begin
                    dcnt_d = dcnt_q + DCW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            dcnt_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            dcnt_q  <= dcnt_d;
            x_q     <= x_rdata;
            y_q     <= y_rdata;
            wdata_q <= acc_in;
        end
    end

    // y address is (j+1) mod N without a divider: only j = N-1 and j = N
    // wrap.
    always_comb begin
        y_raddr = '0;
        if (j_q == J_LAST) begin
            y_raddr = Y_AFTER_LAST;
        end else if (j_q != J_WRAP) begin
            y_raddr = j_q[ADDR_W-1:0] + ADDR_W'(1);
        end
    end

    always_comb begin
        tag_in     = '0;
        tag_in.vld = push_vld;
        if (push_vld) begin
            tag_in.addr[ADDR_W:0] = j_q;
        end
    end

    iddmm_tag_pipe #(
        .DEPTH (D)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    // Upper tag address bits are always zero for this word count.
    assign tag_addr_unused = ^tag_out.addr[TAG_ADDR_W-1:ADDR_W+1];

    assign busy      = (state_q == INNER) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign x_raddr   = i_q;
    assign i_cnt     = i_q;
    assign j_cnt     = j_q;
    assign x         = x_q;
    assign y_adv     = y_q;
    assign wr_a_en   = tag_out.vld;
    assign wr_a_addr = tag_out.addr[ADDR_W:0];
    assign wr_a_data = wdata_q;

`ifdef IDDMM_LOOP_CTRL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            perf_q <= '0;
        end else if (busy && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule
